video_proc_pipe: RTL and testbench
==================================

// Module: video_proc_pipe
// PURPOSE
//  Parametrised successor to the single-mode student processing stage; sits between adc_controller and dac_controller.
//  Per-pixel video pipeline with four run-time modes: passthrough, threshold, horizontal edge, vertical edge.
//  Vertical edge uses an internal one-line buffer. Output is aligned to a fixed latency with its own valid strobes.
// PARAMETERS
//  DATA_W    8     pixel width, bits
//  LINE_MAX  1024  max stored pixels per line (line-buffer depth)
//  ADDR_W    20    video_address width
// PORTS
//  clk                 in   1       108 MHz pixel clock; the only clock
//  reset               in   1       synchronous, active-low
//  mode                in   2       0 pass, 1 threshold, 2 h-edge, 3 v-edge
//  threshold           in   DATA_W  binarise level (mode 1)
//  video_frame_valid   in   1       high during active frame
//  video_line_valid    in   1       high during active line
//  video_data_valid    in   1       pixel strobe
//  video_data_in       in   DATA_W  pixel
//  video_address       in   ADDR_W  pixel address, forwarded unchanged, delayed
//  video_data_ready    out  1       output pixel strobe
//  video_data_out      out  DATA_W  processed pixel
//  video_address_out   out  ADDR_W  address aligned with video_data_out
//  frame_count         out  16      completed frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (reset==0 at clk edge): all outputs 0, FSM->IDLE, col=0, line_first=1, mode_q=0; buffer contents don't-care.
//  FSM: IDLE -(frame_valid==1)-> WAIT_LINE; WAIT_LINE -(line_valid rise)-> ACTIVE;
//   ACTIVE -(line_valid fall)-> WAIT_LINE; any state -(frame_valid==0)-> IDLE.
//   IDLE entered while frame_valid is already high goes to WAIT_LINE without a rise; first partial line is processed.
//  mode_q/thr_q latched only on IDLE->WAIT_LINE; mid-frame changes take effect next frame.
//  frame_count increments on frame_valid fall (ACTIVE/WAIT_LINE->IDLE).
//  col counter: cleared on line_valid rise; +1 per data_valid in ACTIVE; saturates at LINE_MAX.
//  Latency: exactly 2 clk from data_valid to video_data_ready; data/address delayed identically.
//  data_valid outside ACTIVE is ignored (no output strobe).
//  video_data_out holds its last value while ready==0.
//  Mode 0: out = in.
//  Mode 1: out = (in >= thr_q) ? all-ones : 0.
//  Mode 2: out = |in - prev_px|, unsigned, DATA_W bits, cannot overflow; prev_px=0 at first pixel of line.
//  Mode 3: out = |in - buf[col]|; buf[col] <= in on same strobe (read-before-write).
//   First line of frame (line_first==1): out = 0. line_first clears at end of first line.
//   col >= LINE_MAX: out = in (not stored).
//  Simultaneous line_valid fall and data_valid: pixel is processed, then the transition is taken.
//  Reset mid-line: pipeline flushed; no ready pulse for in-flight pixels.
// CONFIGURATION
//  VIDEO_PROC_STATS_EN defined: extra output hot_count[ADDR_W-1:0] = pixels with in >= thr_q in the last completed frame.
//   Internal accumulator cleared at frame start; hot_count updated on frame_valid fall; reset value 0.
//  Undefined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  Package video_proc_pkg: mode enum (MODE_PASS/THR/HEDGE/VEDGE), FSM state enum, LATENCY=2 localparam.
//  Sub-module line_buffer (1R1W sync RAM, LINE_MAX x DATA_W, registered read) for mode 3; remaining logic stays in one module.
// TESTING
//  1. mode=0; 8-px line 0..7 -> out 0..7, ready 2 clk after each strobe, address matched.
//  2. mode=1, thr=0x80; px 0x7F,0x80,0xFF -> 0x00,0xFF,0xFF.
//  3. mode=2; line 10,30,25 -> 10,20,5; next line restarts with prev_px=0.
//  4. mode=3; line1 all 0x40, line2 all 0x50 -> line1 out 0, line2 out 0x10; LINE_MAX=4 with 6-px line -> px 5,6 passthrough.
//  5. mode set to 1 mid-frame -> current frame stays mode 0; next frame thresholds; frame_count +1 per frame; 0xFFFF wraps to 0.
//  6. reset low mid-line with 2 px in flight -> no ready pulse; outputs 0 next clk; FSM resumes on next frame.

Source files
------------

// File: rtl/video_proc_pkg.sv
// Shared types and constants for the video processing pipeline.
package video_proc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_THR   = 2'd1,
    MODE_HEDGE = 2'd2,
    MODE_VEDGE = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StWaitLine,
    StActive
  } state_e;

  // Clocks from an accepted input strobe to the matching output strobe.
  localparam int unsigned LATENCY = 2;

endpackage

// File: rtl/video_proc_pipe_line_buffer.sv
// One-line pixel store for vertical edge mode: single-port sync RAM, read-before-write.
module line_buffer
  import video_proc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Nonblocking read and write on the same edge return the previous line's pixel.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_o      <= mem[addr_i];
      mem[addr_i]  <= wdata_i;
    end
  end

endmodule

// File: rtl/video_proc_pipe.sv
// Per-pixel video pipeline (pass / threshold / h-edge / v-edge), fixed 2-clock latency.
// Optional hot-pixel statistics output enabled by defining VIDEO_PROC_STATS_EN.
module video_proc_pipe
  import video_proc_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LINE_MAX = 1024,
  parameter int unsigned ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] threshold,
  input  logic              video_frame_valid,
  input  logic              video_line_valid,
  input  logic              video_data_valid,
  input  logic [DATA_W-1:0] video_data_in,
  input  logic [ADDR_W-1:0] video_address,
  output logic              video_data_ready,
  output logic [DATA_W-1:0] video_data_out,
  output logic [ADDR_W-1:0] video_address_out,
`ifdef VIDEO_PROC_STATS_EN
  output logic [ADDR_W-1:0] hot_count,
`endif
  output logic [15:0]       frame_count
);

  localparam int unsigned COL_W  = $clog2(LINE_MAX + 1);
  localparam int unsigned BUF_AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

  function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    return (a >= b) ? a - b : b - a;
  endfunction

  state_e            state_q, state_d;
  mode_e             mode_q;
  logic [DATA_W-1:0] thr_q;
  logic              lv_q;
  logic [COL_W-1:0]  col_q;
  logic              line_first_q;
  logic [DATA_W-1:0] prev_q;

  logic              v1_q;
  logic [DATA_W-1:0] px1_q;
  logic [DATA_W-1:0] ref1_q;
  logic [ADDR_W-1:0] addr1_q;
  mode_e             mode1_q;
  logic              first1_q;
  logic              sat1_q;
  logic              hot1_q;

  logic [DATA_W-1:0] buf_rdata;
  logic [DATA_W-1:0] result;

  logic line_rise, line_fall, accept, col_sat, frame_start, frame_end, hot;

  assign line_rise   = video_line_valid & ~lv_q;
  assign line_fall   = ~video_line_valid & lv_q;
  assign accept      = (state_q == StActive) & video_data_valid;
  assign col_sat     = (col_q >= COL_W'(LINE_MAX));
  assign frame_start = (state_q == StIdle) & video_frame_valid;
  assign frame_end   = (state_q != StIdle) & ~video_frame_valid;
  assign hot         = (video_data_in >= thr_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (video_frame_valid) state_d = StWaitLine;
      StWaitLine: if (line_rise) state_d = StActive;
      StActive:   if (line_fall) state_d = StWaitLine;
      default:    state_d = StIdle;
    endcase
    if (!video_frame_valid) state_d = StIdle;
  end

  line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (LINE_MAX),
    .AW     (BUF_AW)
  ) u_line_buffer (
    .clk_i   (clk),
    .en_i    (accept & ~col_sat),
    .addr_i  (col_q[BUF_AW-1:0]),
    .wdata_i (video_data_in),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    result = px1_q;
    unique case (mode1_q)
      MODE_PASS:  result = px1_q;
      MODE_THR:   result = {DATA_W{hot1_q}};
      MODE_HEDGE: result = abs_diff(px1_q, ref1_q);
      MODE_VEDGE: begin
        if (first1_q)    result = '0;
        else if (sat1_q) result = px1_q;
        else             result = abs_diff(px1_q, buf_rdata);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q           <= StIdle;
      mode_q            <= MODE_PASS;
      thr_q             <= '0;
      lv_q              <= 1'b0;
      col_q             <= '0;
      line_first_q      <= 1'b1;
      prev_q            <= '0;
      v1_q              <= 1'b0;
      px1_q             <= '0;
      ref1_q            <= '0;
      addr1_q           <= '0;
      mode1_q           <= MODE_PASS;
      first1_q          <= 1'b0;
      sat1_q            <= 1'b0;
      hot1_q            <= 1'b0;
      video_data_ready  <= 1'b0;
      video_data_out    <= '0;
      video_address_out <= '0;
      frame_count       <= '0;
    end else begin
      state_q <= state_d;
      // Forgetting line_valid in idle lets a line already in progress count as a rise.
      lv_q    <= (state_q == StIdle) ? 1'b0 : video_line_valid;

      if (frame_start) begin
        mode_q       <= mode_e'(mode);
        thr_q        <= threshold;
        line_first_q <= 1'b1;
      end else if ((state_q == StActive) && line_fall) begin
        line_first_q <= 1'b0;
      end

      if (line_rise)              col_q <= '0;
      else if (accept && !col_sat) col_q <= col_q + COL_W'(1);

      if (accept) prev_q <= video_data_in;

      v1_q <= accept;
      if (accept) begin
        px1_q    <= video_data_in;
        ref1_q   <= (col_q == '0) ? '0 : prev_q;
        addr1_q  <= video_address;
        mode1_q  <= mode_q;
        first1_q <= line_first_q;
        sat1_q   <= col_sat;
        hot1_q   <= hot;
      end

      video_data_ready <= v1_q;
      if (v1_q) begin
        video_data_out    <= result;
        video_address_out <= addr1_q;
      end

      if (frame_end) frame_count <= frame_count + 16'd1;
    end
  end

`ifdef VIDEO_PROC_STATS_EN
  logic [ADDR_W-1:0] hot_acc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      hot_acc_q <= '0;
      hot_count <= '0;
    end else begin
      if (frame_start)        hot_acc_q <= '0;
      else if (accept && hot) hot_acc_q <= hot_acc_q + ADDR_W'(1);
      // A pixel accepted on the closing edge still belongs to the finished frame.
      if (frame_end) hot_count <= hot_acc_q + ADDR_W'(accept && hot);
    end
  end
`endif

endmodule

// File: tb/tb_video_proc_pipe.sv
// Directed scoreboard bench for video_proc_pipe (built with LINE_MAX=4 to reach saturation).
module tb_video_proc_pipe;
  import video_proc_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned LM = 4;
  localparam int unsigned AW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic [DW-1:0] threshold;
  logic          fv, lv, dv;
  logic [DW-1:0] din;
  logic [AW-1:0] ain;
  logic          ready;
  logic [DW-1:0] dout;
  logic [AW-1:0] aout;
  logic [15:0]   fcnt;
`ifdef VIDEO_PROC_STATS_EN
  logic [AW-1:0] hot_count;
`endif

  always #5 clk = ~clk;

  video_proc_pipe #(
    .DATA_W   (DW),
    .LINE_MAX (LM),
    .ADDR_W   (AW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mode              (mode),
    .threshold         (threshold),
    .video_frame_valid (fv),
    .video_line_valid  (lv),
    .video_data_valid  (dv),
    .video_data_in     (din),
    .video_address     (ain),
    .video_data_ready  (ready),
    .video_data_out    (dout),
    .video_address_out (aout),
`ifdef VIDEO_PROC_STATS_EN
    .hot_count         (hot_count),
`endif
    .frame_count       (fcnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    int unsigned   c;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int unsigned   cyc = 0;
  int unsigned   n_checks = 0;
  int unsigned   n_fail = 0;
  logic [AW-1:0] next_addr = 20'h100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every output strobe must match the oldest pending pixel, on time.
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("data", 32'(dout), 32'(mon_e.d));
        check("addr", 32'(aout), 32'(mon_e.a));
        check("latency_cycle", cyc, mon_e.c);
      end
    end
  end

  task automatic tick(input logic f, input logic l, input logic d, input logic [DW-1:0] px);
    @(negedge clk);
    fv  = f;
    lv  = l;
    dv  = d;
    din = px;
    ain = next_addr;
  endtask

  task automatic send(input logic l, input logic [DW-1:0] px, input logic [DW-1:0] exp);
    exp_t e;
    tick(1'b1, l, 1'b1, px);
    e.d = exp;
    e.a = next_addr;
    e.c = cyc + LATENCY;
    sb.push_back(e);
    next_addr = next_addr + 20'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("no_strobe", 32'(ready), 32'd0);
    end
  endtask

  task automatic frame_open();
    tick(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic line_open();
    tick(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic line_close();
    tick(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_close();
    tick(1'b0, 1'b0, 1'b0, 8'h00);
    idle(3);
  endtask

  initial begin
    reset = 1'b0; mode = 2'd0; threshold = '0;
    fv = 1'b0; lv = 1'b0; dv = 1'b0; din = '0; ain = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_data", 32'(dout), 32'd0);
    check("rst_addr", 32'(aout), 32'd0);
    check("rst_frame_count", 32'(fcnt), 32'd0);
    reset = 1'b1;

    // Passthrough; strobes outside an active line are ignored.
    mode = 2'd0;
    frame_open();
    tick(1'b1, 1'b0, 1'b1, 8'h55);
    tick(1'b1, 1'b0, 1'b0, 8'h00);
    quiet(3);
    line_open();
    for (int i = 0; i < 8; i++) send(1'b1, 8'(i), 8'(i));
    line_close();
    frame_close();
    tick(1'b0, 1'b0, 1'b1, 8'h66);
    idle(1);
    quiet(3);
    check("frame_count_1", 32'(fcnt), 32'd1);

    // Threshold at 0x80; output holds while idle.
    mode = 2'd1; threshold = 8'h80;
    frame_open();
    line_open();
    send(1'b1, 8'h7F, 8'h00);
    send(1'b1, 8'h80, 8'hFF);
    send(1'b1, 8'hFF, 8'hFF);
    line_close();
    frame_close();
    check("hold_data", 32'(dout), 32'hFF);
    check("hold_addr", 32'(aout), 32'(next_addr - 20'd1));
    check("frame_count_2", 32'(fcnt), 32'd2);

    // Horizontal edge; last pixel arrives on the line_valid fall.
    mode = 2'd2;
    frame_open();
    line_open();
    send(1'b1, 8'd10, 8'd10);
    send(1'b1, 8'd30, 8'd20);
    send(1'b1, 8'd25, 8'd5);
    line_close();
    line_open();
    send(1'b1, 8'd40, 8'd40);
    send(1'b0, 8'd30, 8'd10);
    frame_close();
    check("frame_count_3", 32'(fcnt), 32'd3);

    // Vertical edge; columns 4 and 5 exceed the buffer and pass through.
    mode = 2'd3;
    frame_open();
    line_open();
    for (int i = 0; i < 4; i++) send(1'b1, 8'h40, 8'h00);
    line_close();
    line_open();
    for (int i = 0; i < 4; i++) send(1'b1, 8'h50, 8'h10);
    send(1'b1, 8'h50, 8'h50);
    send(1'b1, 8'h50, 8'h50);
    line_close();
    line_open();
    for (int i = 0; i < 4; i++) send(1'b1, 8'h30, 8'h20);
    line_close();
    frame_close();
    check("frame_count_4", 32'(fcnt), 32'd4);

    // Mode change mid-frame only applies from the next frame.
    mode = 2'd0; threshold = 8'h00;
    frame_open();
    line_open();
    send(1'b1, 8'h10, 8'h10);
    mode = 2'd1; threshold = 8'h80;
    send(1'b1, 8'h90, 8'h90);
    line_close();
    frame_close();
    check("frame_count_5", 32'(fcnt), 32'd5);
    frame_open();
    line_open();
    send(1'b1, 8'h10, 8'h00);
    send(1'b1, 8'h90, 8'hFF);
    line_close();
    frame_close();
    check("frame_count_6", 32'(fcnt), 32'd6);

    // Reset mid-line flushes in-flight pixels; a line in progress is picked up after.
    mode = 2'd0;
    frame_open();
    line_open();
    tick(1'b1, 1'b1, 1'b1, 8'h11);
    tick(1'b1, 1'b1, 1'b1, 8'h22);
    reset = 1'b0;
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    reset = 1'b1;
    check("flush_ready", 32'(ready), 32'd0);
    check("flush_data", 32'(dout), 32'd0);
    check("flush_addr", 32'(aout), 32'd0);
    check("flush_frame_count", 32'(fcnt), 32'd0);
    tick(1'b1, 1'b1, 1'b0, 8'h00);
    check("flush_no_strobe", 32'(ready), 32'd0);
    send(1'b1, 8'h33, 8'h33);
    send(1'b1, 8'h44, 8'h44);
    line_close();
    frame_close();
    check("frame_count_after_reset", 32'(fcnt), 32'd1);

    idle(2);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
